// File: rtl/md_k2h_packer_pkg.sv
// Shared constants and types for the kernel-to-host record packer.
package md_k2h_packer_pkg;

   // One MD particle record is 24 bytes; two of them fit in a 512-bit beat.
   localparam int REC_BYTES     = 24;
   localparam int RECS_PER_BEAT = 2;

   // Byte enables for a beat carrying one or two records (low bytes first).
   localparam logic [63:0] KEEP_ONE_REC = 64'((65'd1 << REC_BYTES) - 65'd1);
   localparam logic [63:0] KEEP_TWO_REC = 64'((65'd1 << (REC_BYTES * RECS_PER_BEAT)) - 65'd1);

   // Accumulator state: EMPTY holds nothing, HALF holds one record in slot 0.
   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/md_k2h_packer_if.sv
// AXI-Stream bundle used for the packed kernel-to-host output.
interface md_k2h_packer_if #(
   parameter int DATA_W = 512,
   parameter int DEST_W = 16
) ();

   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid;
   logic                tlast;
   logic [DEST_W-1:0]   tdest;
   logic                tready;

   modport master (
      output tdata, tkeep, tvalid, tlast, tdest,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tdest,
      output tready
   );

endinterface

// File: rtl/md_k2h_packer_out_reg.sv
// Output holding register: keeps a beat stable until the sink takes it.
module md_axis_out_reg #(
   parameter int DATA_W = 512,
   parameter int DEST_W = 16
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic [DATA_W-1:0]   load_data,
   input  logic [DATA_W/8-1:0] load_keep,
   input  logic                load_last,
   input  logic [DEST_W-1:0]   load_dest,
   md_k2h_packer_if.master     m_axis
);

   // Load a new beat, drop it on clear, or retire it once the sink accepts it.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
         m_axis.tdata  <= '0;
         m_axis.tkeep  <= '0;
         m_axis.tdest  <= '0;
      end else if (clear) begin
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
         m_axis.tdata  <= '0;
         m_axis.tkeep  <= '0;
         m_axis.tdest  <= '0;
      end else if (load) begin
         m_axis.tvalid <= 1'b1;
         m_axis.tlast  <= load_last;
         m_axis.tdata  <= load_data;
         m_axis.tkeep  <= load_keep;
         m_axis.tdest  <= load_dest;
      end else if (m_axis.tvalid && m_axis.tready) begin
         m_axis.tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/md_k2h_packer.sv
// Packs 192-bit MD particle records two per AXI-Stream beat toward the host.
module md_k2h_packer
   import md_k2h_packer_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH      = 512,
   parameter int STREAMING_TDEST_WIDTH = 16,
   parameter int REC_WIDTH             = 192
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic [REC_WIDTH-1:0]             s_rec_data,
   input  logic                             s_rec_valid,
   input  logic                             s_rec_last,
   output logic                             s_rec_ready,
   input  logic [STREAMING_TDEST_WIDTH-1:0] cfg_dest,
   input  logic [15:0]                      cfg_beats_per_pkt,
   input  logic                             soft_clear,
   md_k2h_packer_if.master                  m_axis_k2h,
   output logic [31:0]                      pkt_count,
   output logic [31:0]                      rec_count
);

   localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;

   acc_state_e                       state_q;
   acc_state_e                       state_d;
   logic [REC_WIDTH-1:0]             slot0_q;
   logic [15:0]                      beat_idx_q;
   logic [STREAMING_TDEST_WIDTH-1:0] dest_q;

   logic                             rec_fire;
   logic                             hold_rec;
   logic                             beat_load;
   logic                             beat_last;
   logic [AXIS_TDATA_WIDTH-1:0]      beat_data;
   logic [KEEP_W-1:0]                beat_keep;
   logic [STREAMING_TDEST_WIDTH-1:0] beat_dest;

   // A record can only enter when the output register is free or draining this cycle.
   assign s_rec_ready = (!m_axis_k2h.tvalid | m_axis_k2h.tready) & !soft_clear;
   assign rec_fire    = s_rec_valid & s_rec_ready;

   // A beat closes its packet on the step's last record or when the configured length is reached;
   // the >= comparison lets a shortened length take effect mid-packet.
   assign beat_last = s_rec_last |
                      ((cfg_beats_per_pkt != 16'd0) && (beat_idx_q >= (cfg_beats_per_pkt - 16'd1)));

   // The first beat of a packet takes the live cfg_dest; later beats reuse the latched copy.
   assign beat_dest = (beat_idx_q == 16'd0) ? cfg_dest : dest_q;

   // Accumulator next state and beat assembly.
   always_comb begin
      state_d   = state_q;
      hold_rec  = 1'b0;
      beat_load = 1'b0;
      beat_data = '0;
      beat_keep = '0;
      case (state_q)
         EMPTY: begin
            if (rec_fire) begin
               if (s_rec_last) begin
                  beat_load                  = 1'b1;
                  beat_data[REC_WIDTH-1:0]   = s_rec_data;
                  beat_keep                  = KEEP_W'(KEEP_ONE_REC);
               end else begin
                  hold_rec = 1'b1;
                  state_d  = HALF;
               end
            end
         end
         HALF: begin
            if (rec_fire) begin
               beat_load                             = 1'b1;
               beat_data[REC_WIDTH-1:0]              = slot0_q;
               beat_data[2*REC_WIDTH-1:REC_WIDTH]    = s_rec_data;
               beat_keep                             = KEEP_W'(KEEP_TWO_REC);
               state_d                               = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Accumulator state, held record, beat index and latched destination.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= EMPTY;
         slot0_q    <= '0;
         beat_idx_q <= 16'd0;
         dest_q     <= '0;
      end else if (soft_clear) begin
         state_q    <= EMPTY;
         slot0_q    <= '0;
         beat_idx_q <= 16'd0;
         dest_q     <= '0;
      end else begin
         state_q <= state_d;
         if (hold_rec) begin
            slot0_q <= s_rec_data;
         end
         if (beat_load) begin
            beat_idx_q <= beat_last ? 16'd0 : (beat_idx_q + 16'd1);
            if (beat_idx_q == 16'd0) begin
               dest_q <= cfg_dest;
            end
         end
      end
   end

   // Packet and record statistics, flushed by soft_clear.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         pkt_count <= 32'd0;
         rec_count <= 32'd0;
      end else if (soft_clear) begin
         pkt_count <= 32'd0;
         rec_count <= 32'd0;
      end else begin
         if (m_axis_k2h.tvalid && m_axis_k2h.tready && m_axis_k2h.tlast) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (rec_fire) begin
            rec_count <= rec_count + 32'd1;
         end
      end
   end

   md_axis_out_reg #(
      .DATA_W (AXIS_TDATA_WIDTH),
      .DEST_W (STREAMING_TDEST_WIDTH)
   ) u_out_reg (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .clear     (soft_clear),
      .load      (beat_load),
      .load_data (beat_data),
      .load_keep (beat_keep),
      .load_last (beat_last),
      .load_dest (beat_dest),
      .m_axis    (m_axis_k2h)
   );

endmodule

// File: tb/tb_md_k2h_packer.sv
// Directed bench for md_k2h_packer: records in, captured beats checked against hand-built values.
module tb_md_k2h_packer;

   localparam logic [63:0] KEEP1 = 64'h0000_0000_00FF_FFFF;
   localparam logic [63:0] KEEP2 = 64'h0000_FFFF_FFFF_FFFF;

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic [15:0]  dest;
      int           cyc;
   } beat_t;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic [191:0] s_rec_data;
   logic         s_rec_valid;
   logic         s_rec_last;
   logic         s_rec_ready;
   logic [15:0]  cfg_dest;
   logic [15:0]  cfg_beats_per_pkt;
   logic         soft_clear;
   logic [31:0]  pkt_count;
   logic [31:0]  rec_count;

   int           vec_count   = 0;
   int           miscompares = 0;
   int           cyc         = 0;
   beat_t        beat_q[$];

   md_k2h_packer_if #(.DATA_W(512), .DEST_W(16)) axis_if ();

   md_k2h_packer #(
      .AXIS_TDATA_WIDTH      (512),
      .STREAMING_TDEST_WIDTH (16),
      .REC_WIDTH             (192)
   ) dut (
      .ap_clk            (ap_clk),
      .ap_rst_n          (ap_rst_n),
      .s_rec_data        (s_rec_data),
      .s_rec_valid       (s_rec_valid),
      .s_rec_last        (s_rec_last),
      .s_rec_ready       (s_rec_ready),
      .cfg_dest          (cfg_dest),
      .cfg_beats_per_pkt (cfg_beats_per_pkt),
      .soft_clear        (soft_clear),
      .m_axis_k2h        (axis_if),
      .pkt_count         (pkt_count),
      .rec_count         (rec_count)
   );

   always #5 ap_clk = ~ap_clk;

   // Cycle counter used to timestamp captured beats.
   always @(posedge ap_clk) cyc <= cyc + 1;

   // Capture every beat that will handshake on the coming rising edge.
   initial begin
      forever begin
         @(negedge ap_clk);
         #2;
         if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
            beat_q.push_back('{data: axis_if.tdata, keep: axis_if.tkeep,
                               last: axis_if.tlast, dest: axis_if.tdest, cyc: cyc});
         end
      end
   end

   // Hard stop in case something hangs.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [191:0] mk_rec(input logic [7:0] tag);
      return {24{tag}};
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vec_count++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one record at a negedge and return at the negedge after it was accepted.
   task automatic applyStimulus(input logic [7:0] tag, input logic last);
      int wait_cyc = 0;
      s_rec_data  = mk_rec(tag);
      s_rec_last  = last;
      s_rec_valid = 1'b1;
      #1;
      while (s_rec_ready !== 1'b1 && wait_cyc < 50) begin
         @(negedge ap_clk);
         #1;
         wait_cyc++;
      end
      if (s_rec_ready !== 1'b1) begin
         checkOutput("rec_accept_timeout", 512'(s_rec_ready), 512'd1);
      end
      @(negedge ap_clk);
      s_rec_valid = 1'b0;
      s_rec_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge ap_clk);
   endtask

   task automatic checkCount(input string tag, input int n);
      idle(3);
      checkOutput(tag, 512'(beat_q.size()), 512'(n));
   endtask

   task automatic checkBeat(input string tag, input logic [511:0] d, input logic [63:0] k,
                            input logic l, input logic [15:0] dst, output int bcyc);
      beat_t b;
      bcyc = 0;
      if (beat_q.size() == 0) begin
         checkOutput({tag, "_present"}, 512'(beat_q.size()), 512'd1);
         return;
      end
      b    = beat_q.pop_front();
      bcyc = b.cyc;
      checkOutput({tag, "_data"}, b.data, d);
      checkOutput({tag, "_keep"}, 512'(b.keep), 512'(k));
      checkOutput({tag, "_last"}, 512'(b.last), 512'(l));
      checkOutput({tag, "_dest"}, 512'(b.dest), 512'(dst));
   endtask

   task automatic checkCounters(input string tag, input int pkts, input int recs);
      checkOutput({tag, "_pkt_count"}, 512'(pkt_count), 512'(pkts));
      checkOutput({tag, "_rec_count"}, 512'(rec_count), 512'(recs));
   endtask

   // Directed sequence.
   initial begin
      int c1, c2;
      ap_rst_n          = 1'b0;
      s_rec_data        = '0;
      s_rec_valid       = 1'b0;
      s_rec_last        = 1'b0;
      cfg_dest          = 16'h0000;
      cfg_beats_per_pkt = 16'd0;
      soft_clear        = 1'b0;
      axis_if.tready    = 1'b1;

      // Reset state.
      idle(2);
      #1;
      checkOutput("rst_tvalid", 512'(axis_if.tvalid), 512'd0);
      checkOutput("rst_tlast",  512'(axis_if.tlast),  512'd0);
      checkOutput("rst_tdata",  axis_if.tdata, 512'd0);
      checkOutput("rst_tkeep",  512'(axis_if.tkeep), 512'd0);
      checkOutput("rst_tdest",  512'(axis_if.tdest), 512'd0);
      checkOutput("rst_ready",  512'(s_rec_ready), 512'd1);
      checkCounters("rst", 0, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      idle(2);

      // Four records, last on the fourth.
      applyStimulus(8'hA0, 1'b0);
      applyStimulus(8'hB0, 1'b0);
      applyStimulus(8'hC0, 1'b0);
      applyStimulus(8'hD0, 1'b1);
      checkCount("t4_nbeats", 2);
      checkBeat("t4_b0", 512'({mk_rec(8'hB0), mk_rec(8'hA0)}), KEEP2, 1'b0, 16'h0000, c1);
      checkBeat("t4_b1", 512'({mk_rec(8'hD0), mk_rec(8'hC0)}), KEEP2, 1'b1, 16'h0000, c1);
      checkCounters("t4", 1, 4);

      // Three records, the odd one closes the step as a one-record beat.
      applyStimulus(8'h31, 1'b0);
      applyStimulus(8'h32, 1'b0);
      applyStimulus(8'h33, 1'b1);
      checkCount("t3_nbeats", 2);
      checkBeat("t3_b0", 512'({mk_rec(8'h32), mk_rec(8'h31)}), KEEP2, 1'b0, 16'h0000, c1);
      checkBeat("t3_b1", 512'(mk_rec(8'h33)), KEEP1, 1'b1, 16'h0000, c1);
      checkCounters("t3", 2, 7);

      // Fixed two-beat packets, eight records without last.
      cfg_beats_per_pkt = 16'd2;
      cfg_dest          = 16'h0005;
      for (int i = 0; i < 8; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
      checkCount("len_nbeats", 4);
      for (int i = 0; i < 4; i++) begin
         checkBeat($sformatf("len_b%0d", i),
                   512'({mk_rec(8'h41 + 8'(2*i)), mk_rec(8'h40 + 8'(2*i))}),
                   KEEP2, (i % 2 == 1), 16'h0005, c1);
      end
      checkCounters("len", 4, 15);

      // Destination latched on the first beat of a packet.
      cfg_dest = 16'h0007;
      applyStimulus(8'h51, 1'b0);
      applyStimulus(8'h52, 1'b0);
      cfg_dest = 16'h0009;
      applyStimulus(8'h53, 1'b0);
      applyStimulus(8'h54, 1'b0);
      checkCount("dst_nbeats", 2);
      checkBeat("dst_b0", 512'({mk_rec(8'h52), mk_rec(8'h51)}), KEEP2, 1'b0, 16'h0007, c1);
      checkBeat("dst_b1", 512'({mk_rec(8'h54), mk_rec(8'h53)}), KEEP2, 1'b1, 16'h0007, c1);

      // Packet length shortened mid-packet closes it at once.
      cfg_beats_per_pkt = 16'd4;
      for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
      cfg_beats_per_pkt = 16'd2;
      applyStimulus(8'h64, 1'b0);
      applyStimulus(8'h65, 1'b0);
      checkCount("shrink_nbeats", 3);
      checkBeat("shrink_b0", 512'({mk_rec(8'h61), mk_rec(8'h60)}), KEEP2, 1'b0, 16'h0009, c1);
      checkBeat("shrink_b1", 512'({mk_rec(8'h63), mk_rec(8'h62)}), KEEP2, 1'b0, 16'h0009, c1);
      checkBeat("shrink_b2", 512'({mk_rec(8'h65), mk_rec(8'h64)}), KEEP2, 1'b1, 16'h0009, c1);
      checkCounters("shrink", 6, 25);
      cfg_beats_per_pkt = 16'd0;

      // Back-pressure: beat held stable, input stalled, then two beats back to back.
      cfg_dest       = 16'h0003;
      axis_if.tready = 1'b0;
      applyStimulus(8'h71, 1'b0);
      applyStimulus(8'h72, 1'b0);
      s_rec_data  = mk_rec(8'h73);
      s_rec_last  = 1'b1;
      s_rec_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("stall_ready_%0d", i), 512'(s_rec_ready), 512'd0);
         checkOutput($sformatf("stall_tdata_%0d", i), axis_if.tdata,
                     512'({mk_rec(8'h72), mk_rec(8'h71)}));
         @(negedge ap_clk);
      end
      #1;
      checkOutput("stall_tvalid", 512'(axis_if.tvalid), 512'd1);
      checkOutput("stall_tlast",  512'(axis_if.tlast), 512'd0);
      checkOutput("stall_tdest",  512'(axis_if.tdest), 512'h3);
      axis_if.tready = 1'b1;
      @(negedge ap_clk);
      s_rec_valid = 1'b0;
      s_rec_last  = 1'b0;
      checkCount("stall_nbeats", 2);
      checkBeat("stall_b0", 512'({mk_rec(8'h72), mk_rec(8'h71)}), KEEP2, 1'b0, 16'h0003, c1);
      checkBeat("stall_b1", 512'(mk_rec(8'h73)), KEEP1, 1'b1, 16'h0003, c2);
      checkOutput("stall_b2b_gap", 512'(c2 - c1), 512'd1);
      checkCounters("stall", 7, 28);

      // soft_clear drops a stalled beat and zeroes the counters.
      axis_if.tready = 1'b0;
      applyStimulus(8'h81, 1'b0);
      applyStimulus(8'h82, 1'b0);
      soft_clear = 1'b1;
      #1;
      checkOutput("clr_ready", 512'(s_rec_ready), 512'd0);
      @(negedge ap_clk);
      soft_clear = 1'b0;
      #1;
      checkOutput("clr_tvalid", 512'(axis_if.tvalid), 512'd0);
      checkCounters("clr", 0, 0);
      axis_if.tready = 1'b1;
      checkCount("clr_nbeats", 0);

      // soft_clear in HALF discards the held record and beats a simultaneous record.
      applyStimulus(8'h91, 1'b0);
      soft_clear  = 1'b1;
      s_rec_data  = mk_rec(8'h92);
      s_rec_valid = 1'b1;
      @(negedge ap_clk);
      soft_clear  = 1'b0;
      s_rec_valid = 1'b0;
      #1;
      checkCounters("clr_half", 0, 0);
      applyStimulus(8'h93, 1'b0);
      applyStimulus(8'h94, 1'b1);
      checkCount("clr_half_nbeats", 1);
      checkBeat("clr_half_b0", 512'({mk_rec(8'h94), mk_rec(8'h93)}), KEEP2, 1'b1, 16'h0003, c1);
      checkCounters("clr_half_end", 1, 2);

      // Reset pulse with a beat pending clears outputs immediately.
      axis_if.tready = 1'b0;
      applyStimulus(8'hE1, 1'b0);
      applyStimulus(8'hE2, 1'b0);
      ap_rst_n = 1'b0;
      #1;
      checkOutput("mrst_tvalid", 512'(axis_if.tvalid), 512'd0);
      checkOutput("mrst_tdata",  axis_if.tdata, 512'd0);
      checkOutput("mrst_tkeep",  512'(axis_if.tkeep), 512'd0);
      checkOutput("mrst_tdest",  512'(axis_if.tdest), 512'd0);
      checkOutput("mrst_ready",  512'(s_rec_ready), 512'd1);
      checkCounters("mrst", 0, 0);
      @(negedge ap_clk);
      ap_rst_n       = 1'b1;
      axis_if.tready = 1'b1;

      // Reset pulse while in HALF: held record is lost, restart from EMPTY.
      applyStimulus(8'hF1, 1'b0);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      applyStimulus(8'hF2, 1'b1);
      checkCount("mrst_nbeats", 1);
      checkBeat("mrst_b0", 512'(mk_rec(8'hF2)), KEEP1, 1'b1, 16'h0003, c1);
      checkCounters("mrst_end", 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
